// File: rtl/rec_order_sched_pkg.sv
// Shared types, defaults and the round-robin pick helper for the order scheduler.
package rec_order_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STREAM,
        DONE
    } state_e;

    localparam int unsigned ORDER_IMGS_DEF  = 50;
    localparam int unsigned ORDER_DEPTH_DEF = 5;
    localparam int unsigned RR_MAX          = 32;

    // First set bit of req at or above ptr, wrapping within n bits; returns n when none.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                            input int unsigned        ptr,
                                            input int unsigned        n);
        int unsigned idx;
        rr_pick = n;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            if (k < n) begin
                idx = ptr + k;
                if (idx >= n) idx = idx - n;
                if (rr_pick == n && req[idx[$clog2(RR_MAX)-1:0]]) rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/rec_order_sched_fifo.sv
// Synchronous FIFO of requester IDs; push when full and pop when empty are ignored.
module order_id_fifo #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 5,
    localparam int unsigned CW   = $clog2(DEPTH + 1),
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_id,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= push_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/rec_order_sched.sv
// Round-robin order arbiter feeding an ID queue, and the sequencer that gates
// rec_en for ORDER_IMGS beats per order before reporting completion.
module rec_order_sched
    import rec_order_sched_pkg::*;
#(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned ORDER_DEPTH = ORDER_DEPTH_DEF,
    parameter int unsigned ORDER_IMGS  = ORDER_IMGS_DEF,
    parameter int unsigned IDW         = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] ack,
    input  logic            on,
    input  logic            off,
    input  logic            valid,
    input  logic            abort,
    output logic            rec_en,
    output logic            order_come,
    output logic [IDW-1:0]  cur_id,
    output logic [5:0]      beat_cnt,
    output logic [NREQ-1:0] done,
    output logic            aborted,
    output logic            order_full,
    output logic            no_order,
    output logic            busy
);

    localparam int unsigned CW = $clog2(ORDER_DEPTH + 1);

    state_e            state_q, state_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic              order_come_q, order_come_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    cur_id_q, cur_id_d;
    logic [5:0]        beat_q, beat_d;
    logic              aborted_q, aborted_d;
    logic              push, pop, q_full, q_empty;
    logic [IDW-1:0]    push_id, head;
    logic [CW-1:0]     q_count;
    logic [RR_MAX-1:0] req_ext;
    int unsigned       pick;

    order_id_fifo #(
        .WIDTH (IDW),
        .DEPTH (ORDER_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .push_id (push_id),
        .pop     (pop),
        .head    (head),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    // A requester whose ack is still visible has not had a chance to drop req yet.
    always_comb begin
        req_ext              = '0;
        req_ext[NREQ-1:0]    = req & ~ack_q;
        pick                 = rr_pick(req_ext, 32'(rr_q), NREQ);
        push                 = 1'b0;
        push_id              = '0;
        ack_d                = '0;
        order_come_d         = 1'b0;
        rr_d                 = rr_q;
        if (!q_full && pick < NREQ) begin
            push         = 1'b1;
            push_id      = IDW'(pick);
            ack_d        = NREQ'(1) << pick;
            order_come_d = 1'b1;
            rr_d         = (pick + 1 >= NREQ) ? '0 : IDW'(pick + 1);
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_id_d  = cur_id_q;
        beat_d    = beat_q;
        aborted_d = 1'b0;
        pop       = 1'b0;
        rec_en    = 1'b0;
        done      = '0;
        case (state_q)
            IDLE: begin
                if (!q_empty && on && !off) state_d = LOAD;
            end
            LOAD: begin
                pop      = 1'b1;
                cur_id_d = head;
                beat_d   = '0;
                state_d  = STREAM;
            end
            STREAM: begin
                rec_en = on && !off;
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (rec_en && valid) begin
                    beat_d = beat_q + 6'd1;
                    if (beat_d == 6'(ORDER_IMGS)) state_d = DONE;
                end
            end
            DONE: begin
                done    = NREQ'(1) << cur_id_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ack_q        <= '0;
            order_come_q <= 1'b0;
            rr_q         <= '0;
            cur_id_q     <= '0;
            beat_q       <= '0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ack_q        <= ack_d;
            order_come_q <= order_come_d;
            rr_q         <= rr_d;
            cur_id_q     <= cur_id_d;
            beat_q       <= beat_d;
            aborted_q    <= aborted_d;
        end
    end

    assign ack        = ack_q;
    assign order_come = order_come_q;
    assign cur_id     = cur_id_q;
    assign beat_cnt   = beat_q;
    assign aborted    = aborted_q;
    assign order_full = q_full;
    assign no_order   = (q_count == '0) && (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_rec_order_sched.sv
// Bench for rec_order_sched: queue-based order model checked every cycle, plus directed scenarios.
module tb_rec_order_sched;

    localparam int NREQ = 4;
    localparam int DEPTH = 5;
    localparam int IMGS = 50;
    localparam int IDW = 2;

    // Model phases of the order being served.
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_STREAM = 2;
    localparam int P_DONE = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic            on, off, valid, abort;
    logic [NREQ-1:0] ack, done;
    logic            rec_en, order_come, aborted, order_full, no_order, busy;
    logic [IDW-1:0]  cur_id;
    logic [5:0]      beat_cnt;

    int n_cmp = 0;
    int n_err = 0;
    bit cmp_en = 0;
    bit hold_req = 0;

    int mq[$];
    int m_ack = -1, m_rr = 0, m_phase = P_IDLE, m_cur = 0, m_beats = 0, m_abt = 0;
    int exp_seq[6] = '{1, 2, 4, 8, 1, 0};

    rec_order_sched #(
        .NREQ        (NREQ),
        .ORDER_DEPTH (DEPTH),
        .ORDER_IMGS  (IMGS),
        .IDW         (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .ack        (ack),
        .on         (on),
        .off        (off),
        .valid      (valid),
        .abort      (abort),
        .rec_en     (rec_en),
        .order_come (order_come),
        .cur_id     (cur_id),
        .beat_cnt   (beat_cnt),
        .done       (done),
        .aborted    (aborted),
        .order_full (order_full),
        .no_order   (no_order),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name, input int limit);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no progress within %0d cycles at %0t", name, limit, $time);
    endtask

    // Reference model: a queue of IDs, a rotating priority pointer and the served order.
    task automatic model_step();
        int g, qsz, idx;
        if (!rst_n) begin
            mq.delete();
            m_ack = -1; m_rr = 0; m_phase = P_IDLE; m_cur = 0; m_beats = 0; m_abt = 0;
            return;
        end
        qsz = mq.size();
        g = -1;
        if (qsz < DEPTH)
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && req[idx[1:0]] && idx != m_ack) g = idx;
            end
        m_abt = 0;
        case (m_phase)
            P_IDLE:   if (qsz > 0 && on && !off) m_phase = P_LOAD;
            P_LOAD: begin
                m_cur = mq.pop_front();
                m_beats = 0;
                m_phase = P_STREAM;
            end
            P_STREAM: begin
                if (abort) begin
                    m_phase = P_IDLE;
                    m_abt = 1;
                end else if (on && !off && valid) begin
                    m_beats++;
                    if (m_beats == IMGS) m_phase = P_DONE;
                end
            end
            default:  m_phase = P_IDLE;
        endcase
        if (g >= 0) begin
            mq.push_back(g);
            m_rr = (g + 1) % NREQ;
        end
        m_ack = g;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ack", int'(ack), (m_ack >= 0) ? (1 << m_ack) : 0);
            chk("order_come", int'(order_come), (m_ack >= 0) ? 1 : 0);
            chk("rec_en", int'(rec_en), (m_phase == P_STREAM && on && !off) ? 1 : 0);
            chk("cur_id", int'(cur_id), m_cur);
            chk("beat_cnt", int'(beat_cnt), m_beats);
            chk("done", int'(done), (m_phase == P_DONE) ? (1 << m_cur) : 0);
            chk("aborted", int'(aborted), m_abt);
            chk("order_full", int'(order_full), (mq.size() == DEPTH) ? 1 : 0);
            chk("no_order", int'(no_order), (mq.size() == 0 && m_phase == P_IDLE) ? 1 : 0);
            chk("busy", int'(busy), (m_phase != P_IDLE) ? 1 : 0);
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
        if (!hold_req) req = req & ~ack;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ack"}, int'(ack), 0);
        chk({tag, "_order_come"}, int'(order_come), 0);
        chk({tag, "_rec_en"}, int'(rec_en), 0);
        chk({tag, "_cur_id"}, int'(cur_id), 0);
        chk({tag, "_beat_cnt"}, int'(beat_cnt), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
        chk({tag, "_order_full"}, int'(order_full), 0);
        chk({tag, "_no_order"}, int'(no_order), 1);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0; on = 1'b0; off = 1'b0; valid = 1'b0; abort = 1'b0; hold_req = 0;
        #1;
        check_reset_vals("reset");
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_beat(input int target, input int limit);
        int n = 0;
        while (int'(beat_cnt) != target && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) timeout($sformatf("wait_beat_%0d", target), limit);
    endtask

    // mode 0: plain, 1: pause with off at beat 20, 2: valid toggles every cycle
    task automatic run_order(input int mode, output int lat, output int recs,
                             output int beats, output int donev, output int maxb);
        int t = 0, t_ack = -1, pause_left = 0;
        bit paused = 0;
        lat = -1; recs = 0; beats = 0; donev = 0; maxb = 0;
        req = 4'b0001;
        while (t < 400) begin
            tick();
            t++;
            if (ack != 0 && t_ack < 0) t_ack = t;
            if (done != 0) begin
                donev = int'(done);
                lat = t - t_ack;
                chk("beat_at_done", int'(beat_cnt), IMGS);
                break;
            end
            if (mode == 1) begin
                if (pause_left > 0) begin
                    pause_left--;
                    if (pause_left == 0) off = 1'b0;
                end else if (!paused && beat_cnt == 6'd20 && busy) begin
                    paused = 1;
                    off = 1'b1;
                    pause_left = 10;
                end
            end
            if (mode == 2) valid = ~valid;
            #1;
            if (off) begin
                chk("pause_rec_en", int'(rec_en), 0);
                chk("pause_beat", int'(beat_cnt), 20);
            end
            if (int'(beat_cnt) > maxb) maxb = int'(beat_cnt);
            if (rec_en) recs++;
            if (rec_en && valid) beats++;
        end
        if (lat < 0) timeout($sformatf("run_order_mode%0d", mode), 400);
    endtask

    initial begin
        int lat, recs, beats, donev, maxb, dcount;
        rst_n = 1'b1;
        req = '0; on = 1'b0; off = 1'b0; valid = 1'b0; abort = 1'b0;
        #2;
        cmp_en = 1;
        do_reset();

        // single order, uninterrupted
        on = 1'b1; valid = 1'b1;
        run_order(0, lat, recs, beats, donev, maxb);
        chk("s1_latency", lat, 52);
        chk("s1_rec_cycles", recs, 50);
        chk("s1_done", donev, 1);
        tick();
        chk("s1_no_order_after", int'(no_order), 1);

        // fill the queue with the system disabled
        do_reset();
        hold_req = 1; req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("fill_ack%0d", i), int'(ack), exp_seq[i]);
            if (i >= 4) chk("fill_full", int'(order_full), 1);
        end
        on = 1'b1;
        tick(); chk("full_no_ack_idle", int'(ack), 0);
        tick(); chk("full_no_ack_load", int'(ack), 0);
        tick(); chk("ack_after_pop", int'(ack), 2);
        hold_req = 0; req = '0;
        repeat (5) tick();

        // pause for 10 cycles at beat 20
        do_reset();
        on = 1'b1; valid = 1'b1;
        run_order(1, lat, recs, beats, donev, maxb);
        chk("pause_latency", lat, 62);
        chk("pause_rec_cycles", recs, 50);
        chk("pause_done", donev, 1);

        // valid toggling every cycle
        do_reset();
        on = 1'b1; valid = 1'b1;
        run_order(2, lat, recs, beats, donev, maxb);
        chk("toggle_stream_cycles", recs, 100);
        chk("toggle_beats", beats, 50);
        chk("toggle_max_le_imgs", (maxb <= IMGS) ? 1 : 0, 1);
        chk("toggle_latency", lat, 102);

        // abort at beat 30 with a second order queued
        do_reset();
        on = 1'b1; valid = 1'b1; req = 4'b0011;
        wait_beat(30, 200);
        chk("abort_cur_id_before", int'(cur_id), 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pulse", int'(aborted), 1);
        chk("abort_beat_not_counted", int'(beat_cnt), 30);
        chk("abort_no_done", int'(done), 0);
        chk("abort_idle", int'(busy), 0);
        tick();
        tick();
        chk("abort_next_id", int'(cur_id), 1);
        chk("abort_next_beat0", int'(beat_cnt), 0);
        dcount = 0;
        while (done == 0 && dcount < 100) begin
            tick();
            dcount++;
        end
        if (dcount >= 100) timeout("abort_next_done", 100);
        else chk("abort_next_done", int'(done), 2);

        // reset in the middle of an order with three more queued
        do_reset();
        on = 1'b1; valid = 1'b1; req = 4'b1111;
        wait_beat(10, 100);
        chk("midreset_queued_full_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midreset");
        tick();
        tick();
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (done != 0) dcount++;
        end
        chk("midreset_no_done", dcount, 0);
        chk("midreset_no_order", int'(no_order), 1);

        // randomized traffic
        do_reset();
        on = 1'b1; valid = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if (!req[i] && $urandom_range(0, 9) == 0) req[i] = 1'b1;
            on    = ($urandom_range(0, 15) != 0);
            off   = ($urandom_range(0, 31) == 0);
            valid = ($urandom_range(0, 3) != 0);
            abort = ($urandom_range(0, 99) == 0);
        end
        req = '0; abort = 1'b0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
